// File: rtl/blob_frame_streamer.sv
// Thresholds one grayscale frame into a 1-bpp buffer, then replays it as a gap-free
// raster stream on o_valid/o_seq and holds the valid level until the counter answers.
module blob_frame_streamer #(
    parameter int IMG_COL = 800,
    parameter int IMG_ROW = 600,
    parameter int THRESH  = 128,
    parameter int INVERT  = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pix_valid,
    input  logic       i_sof,
    input  logic [7:0] i_gray,
    output logic       o_valid,
    output logic       o_seq,
    input  logic       i_done,
    output logic       o_busy
);
    localparam int NPIX  = IMG_COL * IMG_ROW;
    localparam int NWORD = NPIX / 16;
    localparam int AW    = (NWORD > 1) ? $clog2(NWORD) : 1;
    localparam logic [18:0] LAST_PIX = 19'(NPIX - 1);
    localparam logic [14:0] N_WORDS  = 15'(NWORD);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_PREFETCH, S_STREAM, S_WAIT, S_RELEASE
    } state_t;

    state_t      r_state, w_next;
    logic [15:0] r_mem [NWORD];
    logic [15:0] r_rdata;
    logic [15:0] r_pack;
    logic [15:0] r_shift;
    logic [18:0] r_pix;
    logic [14:0] r_waddr;
    logic        r_first;

    logic        w_bit, w_start, w_accept, w_wr, w_rd, w_last_cap;
    logic [18:0] w_idx;
    logic [15:0] w_packed;

    assign w_bit      = (i_gray >= 8'(THRESH)) ^ 1'(INVERT);
    assign w_start    = i_pix_valid && i_sof && (r_state == S_IDLE || r_state == S_CAPTURE);
    assign w_accept   = w_start || (r_state == S_CAPTURE && i_pix_valid);
    // A start-of-frame pixel always lands at index 0 with an empty packing word.
    assign w_idx      = w_start ? '0 : r_pix;
    assign w_packed   = (w_start ? 16'd0 : r_pack) | (16'(w_bit) << w_idx[3:0]);
    assign w_wr       = w_accept && (w_idx[3:0] == 4'hF);
    assign w_last_cap = w_accept && (w_idx == LAST_PIX);
    // Next word is fetched while bit 14 goes out, so it is ready when bit 15 leaves.
    assign w_rd       = (r_state == S_PREFETCH) ||
                        (r_state == S_STREAM && !r_first && r_pix[3:0] == 4'd14 &&
                         r_waddr != N_WORDS);
    assign o_busy     = (r_state != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_start) w_next = S_CAPTURE;
            S_CAPTURE:  if (w_last_cap) w_next = S_PREFETCH;
            S_PREFETCH: w_next = S_STREAM;
            S_STREAM:   if (!r_first && r_pix == LAST_PIX) w_next = S_WAIT;
            S_WAIT:     if (i_done) w_next = S_RELEASE;
            S_RELEASE:  if (!i_done) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[w_idx[AW+3:4]] <= w_packed;
        if (w_rd) r_rdata <= r_mem[r_waddr[AW-1:0]];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pix   <= '0;
            r_waddr <= '0;
            r_pack  <= '0;
            r_shift <= '0;
            r_first <= 1'b0;
            o_valid <= 1'b0;
            o_seq   <= 1'b0;
        end else begin
            o_valid <= (r_state == S_STREAM) || (r_state == S_WAIT && !i_done);
            o_seq   <= 1'b0;
            if (w_accept) begin
                r_pix  <= w_idx + 19'd1;
                r_pack <= w_wr ? 16'd0 : w_packed;
            end
            if (w_start) r_waddr <= '0;
            if (w_rd)    r_waddr <= r_waddr + 15'd1;
            case (r_state)
                S_PREFETCH: r_first <= 1'b1;
                S_STREAM: begin
                    // First stream cycle (T) loads word 0 and emits a zero.
                    if (r_first) begin
                        r_first <= 1'b0;
                        r_shift <= r_rdata;
                        r_pix   <= '0;
                    end else begin
                        o_seq   <= r_shift[0];
                        r_shift <= (r_pix[3:0] == 4'hF) ? r_rdata : {1'b0, r_shift[15:1]};
                        r_pix   <= r_pix + 19'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_blob_frame_streamer.sv
// Scoreboard bench: expected pixel bits are queued as frames are driven and popped
// as the stream comes out; an INVERT=1 twin checks the inverted decision.
module tb_blob_frame_streamer;
    localparam int NPIX = 128;

    logic       i_clk = 1'b0, i_rst_n = 1'b0, i_pix_valid = 1'b0, i_sof = 1'b0, i_done = 1'b0;
    logic [7:0] i_gray = 8'd0;
    logic       o_valid, o_seq, o_busy;
    logic       v_inv, s_inv, b_inv;

    always #5 i_clk = ~i_clk;

    blob_frame_streamer #(.IMG_COL(32), .IMG_ROW(4), .THRESH(128), .INVERT(0)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pix_valid(i_pix_valid), .i_sof(i_sof),
        .i_gray(i_gray), .o_valid(o_valid), .o_seq(o_seq), .i_done(i_done), .o_busy(o_busy));

    blob_frame_streamer #(.IMG_COL(32), .IMG_ROW(4), .THRESH(128), .INVERT(1)) dut_inv (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pix_valid(i_pix_valid), .i_sof(i_sof),
        .i_gray(i_gray), .o_valid(v_inv), .o_seq(s_inv), .i_done(i_done), .o_busy(b_inv));

    int  n_cmp = 0, n_bad = 0;
    bit  exp_q[$];
    time t_last = 0;
    int  sidx = -1;
    logic prev_v = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Stream monitor: T must be 2 edges after the last accepted pixel, then NPIX bits, then zeros.
    always @(negedge i_clk) begin
        bit e;
        if (!i_rst_n) begin
            sidx   = -1;
            prev_v = 1'b0;
        end else begin
            if (o_valid && !prev_v) begin
                chk("t_rise", 32'($time - 5), 32'(t_last + 20));
                chk("seq_at_T", o_seq, 0);
                chk("inv_valid_at_T", v_inv, 1);
                sidx = 0;
            end else if (o_valid && sidx >= 0 && sidx < NPIX) begin
                if (exp_q.size() == 0) begin
                    chk("queue_empty", 1, 0);
                    sidx = NPIX;
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("pix%0d", sidx), o_seq, e);
                    chk($sformatf("inv_pix%0d", sidx), s_inv, !e);
                    sidx++;
                end
            end else if (o_valid && sidx == NPIX) begin
                chk("tail_zero", o_seq, 0);
                sidx++;
            end else if (!o_valid && prev_v && sidx >= 0 && sidx <= NPIX) begin
                chk("valid_gap", 0, 1);
            end
            if (!o_valid) sidx = -1;
            prev_v = o_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // mode 0: all 255, 1: 127/128 alternating, 3: all 0, else random gray.
    task automatic send_frame(input int mode, input int gap, input int n, input bit push);
        for (int k = 0; k < n; k++) begin
            logic [7:0] g;
            case (mode)
                0:       g = 8'd255;
                1:       g = (k % 2 == 1) ? 8'd128 : 8'd127;
                3:       g = 8'd0;
                default: g = 8'($urandom_range(0, 255));
            endcase
            i_pix_valid = 1'b1;
            i_sof       = (k == 0);
            i_gray      = g;
            @(posedge i_clk);
            if (push) begin
                exp_q.push_back(g >= 8'd128);
                if (k == n - 1) t_last = $time;
            end
            #1;
            i_pix_valid = 1'b0;
            i_sof       = 1'b0;
            repeat (gap) begin
                i_sof  = 1'($urandom_range(0, 1));
                i_gray = 8'($urandom_range(0, 255));
                tick(1);
            end
            i_sof = 1'b0;
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!o_valid && n < 500) begin
            tick(1);
            n++;
        end
        chk("wait_valid_timeout", (n < 500), 1);
    endtask

    task automatic finish_frame();
        int n = 0;
        while (sidx <= NPIX && n < 1000) begin
            tick(1);
            n++;
        end
        chk("stream_timeout", (n < 1000), 1);
        tick(3);
        @(negedge i_clk);
        chk("wait_valid_hold", o_valid, 1);
        chk("wait_seq_zero", o_seq, 0);
        @(posedge i_clk);
        #1 i_done = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("valid_fall", o_valid, 0);
        chk("busy_release", o_busy, 1);
        // A start-of-frame while done is still high must be ignored.
        i_pix_valid = 1'b1;
        i_sof       = 1'b1;
        i_gray      = 8'd255;
        @(posedge i_clk);
        #1;
        i_pix_valid = 1'b0;
        i_sof       = 1'b0;
        i_done      = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("idle_after_release", o_busy, 0);
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #12;
        chk("rst_valid", o_valid, 0);
        chk("rst_seq", o_seq, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_inv_seq", s_inv, 0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        tick(2);

        // Uniform white frame, done pulsed while streaming (must not cut the stream).
        send_frame(0, 0, NPIX, 1);
        chk("busy_capture_done", o_busy, 1);
        tick(10);
        i_done = 1'b1;
        tick(5);
        i_done = 1'b0;
        finish_frame();

        // Threshold boundary with sparse strobes.
        send_frame(1, 2, NPIX, 1);
        finish_frame();

        // Restart: 50 pixels then a fresh sof with a full frame.
        send_frame(2, 0, 50, 0);
        send_frame(2, 0, NPIX, 1);
        finish_frame();

        // Frame arriving mid-stream is dropped; the one after release is kept.
        send_frame(2, 1, NPIX, 1);
        wait_valid();
        send_frame(3, 0, NPIX, 0);
        chk("busy_drop", o_busy, 1);
        finish_frame();
        send_frame(2, 0, NPIX, 1);
        finish_frame();

        // Asynchronous reset mid-stream, then a clean frame.
        send_frame(2, 0, NPIX, 1);
        n = 0;
        while (sidx < 60 && n < 500) begin
            tick(1);
            n++;
        end
        chk("reach_pix60", (n < 500), 1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_seq", o_seq, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_inv_valid", v_inv, 0);
        exp_q.delete();
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        tick(1);
        chk("postrst_idle", o_busy, 0);
        send_frame(2, 0, NPIX, 1);
        finish_frame();

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
